// File: rtl/serial_ctrl_rx.sv
// serial_ctrl_rx: oversampled 8N1 receiver that assembles header/payload frames into control words.
// Define SERIAL_CTRL_RX_CHECKSUM_EN to require a trailing XOR checksum byte in every frame.
module serial_ctrl_rx #(
    parameter int unsigned CLK_PER_BIT = 8,
    parameter int unsigned NBYTES      = 4
) (
    input  logic                sclk,
    input  logic                rst_n,
    input  logic                sdata,
    output logic [8*NBYTES-1:0] ctrl_word,
    output logic                word_valid,
    output logic [7:0]          rx_byte,
    output logic                byte_valid,
    output logic                frame_err,
    output logic [7:0]          err_cnt
);

    localparam int unsigned      PH_W   = $clog2(CLK_PER_BIT);
    localparam int unsigned      IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [PH_W-1:0]  PH_MAX = PH_W'(CLK_PER_BIT - 1);
    localparam logic [PH_W-1:0]  HALF   = PH_W'(CLK_PER_BIT / 2);
    localparam logic [IDX_W-1:0] LAST   = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} byte_state_e;
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
    typedef enum logic [1:0] {StHunt, StPayload, StCheck} frame_state_e;
`else
    typedef enum logic [1:0] {StHunt, StPayload} frame_state_e;
`endif

    // Input path and byte framer state
    logic [1:0]       sync_q;
    logic             rxd_prev_q;
    logic [1:0]       primed_q;
    logic             armed_q;
    byte_state_e      bstate_q;
    logic [PH_W-1:0]  ph_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;

    // Frame assembler state
    frame_state_e     fstate_q;
    logic [NBYTES-1:0] hdr_q;
    logic [IDX_W-1:0] pidx_q;
    logic [8*NBYTES-1:0] pay_q;
    logic [8*NBYTES-1:0] word_next;
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
    logic [6:0]       cks_q;
`endif

    logic rxd;
    logic rxd_edge;
    logic rxd_fall;
    logic stop_fail;
    logic cks_fail;

    assign rxd       = sync_q[1];
    assign rxd_edge  = rxd ^ rxd_prev_q;
    assign rxd_fall  = rxd_prev_q & ~rxd;
    assign stop_fail = (bstate_q == StStop) && !rxd_edge && (ph_q == HALF) && !rxd;

`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
    assign cks_fail = (fstate_q == StCheck) && byte_valid && !rx_byte[7] &&
                      (rx_byte[6:0] != cks_q);
`else
    assign cks_fail = 1'b0;
`endif

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= 2'b11;
            rxd_prev_q <= 1'b1;
            primed_q   <= 2'b00;
            armed_q    <= 1'b0;
            bstate_q   <= StIdle;
            ph_q       <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'h00;
            rx_byte    <= 8'h00;
            byte_valid <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], sdata};
            rxd_prev_q <= rxd;
            primed_q   <= {primed_q[0], 1'b1};
            byte_valid <= 1'b0;
            ph_q       <= (ph_q == PH_MAX) ? '0 : ph_q + PH_W'(1);

            // Only a line seen high after the synchroniser has refilled may arm a start bit.
            if (stop_fail) begin
                armed_q <= 1'b0;
            end else if (primed_q[1] && rxd) begin
                armed_q <= 1'b1;
            end

            case (bstate_q)
                StIdle: begin
                    if (rxd_fall && armed_q) begin
                        ph_q     <= '0;
                        bstate_q <= StStart;
                    end
                end
                StStart: begin
                    if (ph_q == HALF) begin
                        bit_idx_q <= 3'd0;
                        bstate_q  <= rxd ? StIdle : StData;
                    end
                end
                StData: begin
                    if (rxd_edge) begin
                        ph_q <= '0;
                    end else if (ph_q == HALF) begin
                        shift_q[bit_idx_q] <= rxd;
                        if (bit_idx_q == 3'd7) begin
                            bstate_q <= StStop;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                StStop: begin
                    if (rxd_edge) begin
                        ph_q <= '0;
                    end else if (ph_q == HALF) begin
                        if (rxd) begin
                            rx_byte    <= shift_q;
                            byte_valid <= 1'b1;
                        end
                        bstate_q <= StIdle;
                    end
                end
                default: bstate_q <= StIdle;
            endcase
        end
    end

    // Payload image with the current byte merged in at the current index.
    always_comb begin
        word_next = pay_q;
        for (int k = 0; k < NBYTES; k++) begin
            if (IDX_W'(k) == pidx_q) begin
                word_next[8*k +: 8] = {hdr_q[k], rx_byte[6:0]};
            end
        end
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            fstate_q   <= StHunt;
            hdr_q      <= '0;
            pidx_q     <= '0;
            pay_q      <= '0;
            ctrl_word  <= '0;
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            err_cnt    <= 8'h00;
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
            cks_q      <= 7'h00;
`endif
        end else begin
            word_valid <= 1'b0;
            frame_err  <= stop_fail | cks_fail;
            if ((stop_fail || cks_fail) && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end

            if (stop_fail) begin
                fstate_q <= StHunt;
            end else if (byte_valid) begin
                if (rx_byte[7]) begin
                    hdr_q    <= rx_byte[NBYTES-1:0];
                    pidx_q   <= '0;
                    fstate_q <= StPayload;
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
                    cks_q    <= rx_byte[6:0];
`endif
                end else begin
                    case (fstate_q)
                        StPayload: begin
                            pay_q <= word_next;
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
                            cks_q <= cks_q ^ rx_byte[6:0];
                            if (pidx_q == LAST) begin
                                fstate_q <= StCheck;
                            end else begin
                                pidx_q <= pidx_q + IDX_W'(1);
                            end
`else
                            if (pidx_q == LAST) begin
                                ctrl_word  <= word_next;
                                word_valid <= 1'b1;
                                fstate_q   <= StHunt;
                            end else begin
                                pidx_q <= pidx_q + IDX_W'(1);
                            end
`endif
                        end
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
                        StCheck: begin
                            if (!cks_fail) begin
                                ctrl_word  <= pay_q;
                                word_valid <= 1'b1;
                            end
                            fstate_q <= StHunt;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_ctrl_rx.sv
// Self-checking bench for serial_ctrl_rx: table of framed byte streams plus hand-written corner cases.
module tb_serial_ctrl_rx;

    localparam int unsigned CPB = 8;
    localparam int unsigned NB  = 4;

    logic          sclk  = 1'b0;
    logic          rst_n = 1'b0;
    logic          sdata = 1'b1;
    logic [31:0]   ctrl_word;
    logic          word_valid;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic          frame_err;
    logic [7:0]    err_cnt;

    serial_ctrl_rx #(
        .CLK_PER_BIT(CPB),
        .NBYTES     (NB)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .sdata     (sdata),
        .ctrl_word (ctrl_word),
        .word_valid(word_valid),
        .rx_byte   (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err),
        .err_cnt   (err_cnt)
    );

    always #5 sclk = ~sclk;

    int checks   = 0;
    int failures = 0;
    int n_bv     = 0;
    int n_wv     = 0;
    int n_fe     = 0;

    always @(negedge sclk) begin
        if (byte_valid) n_bv++;
        if (word_valid) n_wv++;
        if (frame_err)  n_fe++;
    end

    // Byte i of a stream lives in bytes[8*i +: 8]; bit i of bad_stop sends that byte with stop=0.
    typedef struct {
        int          n;
        logic [63:0] bytes;
        logic [7:0]  bad_stop;
        int          cpb;
        int          exp_bv;
        int          exp_wv;
        int          exp_fe;
        logic [31:0] exp_word;
        logic [7:0]  exp_rx;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs [6];
    int   nvec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge sclk);
        #1;
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic stop_bit, input int cpb);
        sdata = 1'b0;
        wait_clk(cpb);
        for (int i = 0; i < 8; i++) begin
            sdata = b[i];
            wait_clk(cpb);
        end
        sdata = stop_bit;
        wait_clk(cpb);
        sdata = 1'b1;
        wait_clk(4);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        cur;
        logic [7:0]  b;
        int          bv0;
        int          wv0;
        int          fe0;

        // Fields: n, bytes, bad_stop, cpb, exp_bv, exp_wv, exp_fe, exp_word, exp_rx, exp_err
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
        vecs[0] = '{6, 64'h0000_0D78_5634_1285, 8'h00, 8, 6, 1, 0, 32'h78D63492, 8'h0D, 8'd0};
        vecs[1] = '{6, 64'h0000_0C78_5634_1285, 8'h00, 8, 6, 0, 1, 32'h78D63492, 8'h0C, 8'd1};
        vecs[2] = '{3, 64'h0000_0000_0022_1181, 8'h04, 8, 2, 0, 1, 32'h78D63492, 8'h11, 8'd2};
        vecs[3] = '{6, 64'h0000_0A2A_5500_7F8A, 8'h00, 8, 6, 1, 0, 32'hAA55807F, 8'h0A, 8'd2};
        vecs[4] = '{8, 64'h0404_0302_0180_1183, 8'h00, 8, 8, 1, 0, 32'h04030201, 8'h04, 8'd2};
        vecs[5] = '{6, 64'h0000_2A2A_552A_55AA, 8'h00, 9, 6, 1, 0, 32'hAA55AA55, 8'h2A, 8'd2};
        nvec = 6;
`else
        vecs[0] = '{5, 64'h0000_0078_5634_1285, 8'h00, 8, 5, 1, 0, 32'h78D63492, 8'h78, 8'd0};
        vecs[1] = '{3, 64'h0000_0000_0022_1181, 8'h04, 8, 2, 0, 1, 32'h78D63492, 8'h11, 8'd1};
        vecs[2] = '{5, 64'h0000_002A_5500_7F8A, 8'h00, 8, 5, 1, 0, 32'hAA55807F, 8'h2A, 8'd1};
        vecs[3] = '{8, 64'h0403_0201_8022_1183, 8'h00, 8, 8, 1, 0, 32'h04030201, 8'h04, 8'd1};
        vecs[4] = '{5, 64'h0000_002A_552A_55AA, 8'h00, 9, 5, 1, 0, 32'hAA55AA55, 8'h2A, 8'd1};
        nvec = 5;
`endif

        // Reset values
        wait_clk(3);
        check("reset ctrl_word", ctrl_word, 32'h0);
        check("reset word_valid", 32'(word_valid), 32'h0);
        check("reset rx_byte", 32'(rx_byte), 32'h0);
        check("reset byte_valid", 32'(byte_valid), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check("reset err_cnt", 32'(err_cnt), 32'h0);
        rst_n = 1'b1;
        wait_clk(5);

        // Two-cycle low glitch on an idle line
        bv0 = n_bv; fe0 = n_fe;
        sdata = 1'b0;
        wait_clk(2);
        sdata = 1'b1;
        wait_clk(40);
        check("glitch byte_valid count", 32'(n_bv - bv0), 32'd0);
        check("glitch frame_err count", 32'(n_fe - fe0), 32'd0);

        for (int v = 0; v < nvec; v++) begin
            cur = vecs[v];
            bv0 = n_bv; wv0 = n_wv; fe0 = n_fe;
            for (int i = 0; i < cur.n; i++) begin
                b = cur.bytes[8*i +: 8];
                tx_byte(b, !cur.bad_stop[i], cur.cpb);
            end
            wait_clk(10);
            check($sformatf("vec%0d byte_valid count", v), 32'(n_bv - bv0), 32'(cur.exp_bv));
            check($sformatf("vec%0d word_valid count", v), 32'(n_wv - wv0), 32'(cur.exp_wv));
            check($sformatf("vec%0d frame_err count", v), 32'(n_fe - fe0), 32'(cur.exp_fe));
            check($sformatf("vec%0d ctrl_word", v), ctrl_word, cur.exp_word);
            check($sformatf("vec%0d rx_byte", v), 32'(rx_byte), 32'(cur.exp_rx));
            check($sformatf("vec%0d err_cnt", v), 32'(err_cnt), 32'(cur.exp_err));
        end

        // err_cnt saturation: each bad stop still pulses frame_err
        bv0 = n_bv; wv0 = n_wv; fe0 = n_fe;
        repeat (256) tx_byte(8'h00, 1'b0, CPB);
        wait_clk(5);
        check("sat err_cnt", 32'(err_cnt), 32'd255);
        check("sat frame_err count", 32'(n_fe - fe0), 32'd256);
        check("sat word_valid count", 32'(n_wv - wv0), 32'd0);

        // Reset in the middle of the third payload byte, line left low across release
        tx_byte(8'h85, 1'b1, CPB);
        tx_byte(8'h12, 1'b1, CPB);
        tx_byte(8'h34, 1'b1, CPB);
        sdata = 1'b0;
        wait_clk(CPB);
        wait_clk(CPB + 3);
        rst_n = 1'b0;
        #1;
        check("midreset ctrl_word", ctrl_word, 32'h0);
        check("midreset rx_byte", 32'(rx_byte), 32'h0);
        check("midreset err_cnt", 32'(err_cnt), 32'h0);
        check("midreset byte_valid", 32'(byte_valid), 32'h0);
        check("midreset word_valid", 32'(word_valid), 32'h0);
        check("midreset frame_err", 32'(frame_err), 32'h0);
        wait_clk(3);
        rst_n = 1'b1;
        bv0 = n_bv; wv0 = n_wv; fe0 = n_fe;
        wait_clk(120);
        check("low-after-reset byte_valid count", 32'(n_bv - bv0), 32'd0);
        check("low-after-reset frame_err count", 32'(n_fe - fe0), 32'd0);
        sdata = 1'b1;
        wait_clk(10);
        tx_byte(8'h80, 1'b1, CPB);
        tx_byte(8'h01, 1'b1, CPB);
        tx_byte(8'h02, 1'b1, CPB);
        tx_byte(8'h03, 1'b1, CPB);
        tx_byte(8'h04, 1'b1, CPB);
`ifdef SERIAL_CTRL_RX_CHECKSUM_EN
        tx_byte(8'h04, 1'b1, CPB);
`endif
        wait_clk(10);
        check("post-reset word_valid count", 32'(n_wv - wv0), 32'd1);
        check("post-reset ctrl_word", ctrl_word, 32'h04030201);
        check("post-reset err_cnt", 32'(err_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
